// File: rtl/cla_multiword_add_seq_pkg.sv
// Shared ALU definitions: sequencer states, default slice width, index sizing
// and the 4-bit lookahead carry unit used to build slice adders.
package alu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } seq_state_t;

    localparam int SLICE_W_DEF = 16;

    typedef struct packed {
        logic [3:0] c;     // carries into bits 0..3 of the group
        logic       gen;   // group generate
        logic       prop;  // group propagate
    } cla4_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic cla4_t cla4(input logic [3:0] g, input logic [3:0] p, input logic cin);
        cla4_t r;
        r.c[0] = cin;
        r.c[1] = g[0] | (p[0] & cin);
        r.c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        r.c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        r.gen  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        r.prop = &p;
        return r;
    endfunction

endpackage

// File: rtl/cla_multiword_add_seq_if.sv
// Request/result bundle between a requester and the multi-word add sequencer.
interface cla_multiword_add_seq_if #(parameter int W = 64);

    logic         start;
    logic         ready;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    modport master (
        output start, op_sub, a, b, c_in,
        input  ready, busy, done, sum, c_out, ovf, zero
    );

    modport slave (
        input  start, op_sub, a, b, c_in,
        output ready, busy, done, sum, c_out, ovf, zero
    );

endinterface

// File: rtl/cla_multiword_add_seq_slice.sv
// Combinational SLICE_W-bit carry-lookahead adder: 4-bit lookahead units
// joined by a group-level lookahead stage. Also exposes the carry into the MSB.
module cla_slice_adder
    import alu_pkg::*;
#(
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               c_msb_in
);

    localparam int N_GRP = SLICE_W / 4;

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;
    logic [N_GRP-1:0]   grp_g;
    logic [N_GRP-1:0]   grp_p;
    logic [N_GRP:0]     grp_c;
    cla4_t              unit;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        grp_g = '0;
        grp_p = '0;
        grp_c = '0;
        c     = '0;
        unit  = '0;
        for (int j = 0; j < N_GRP; j++) begin
            unit     = cla4(g[4*j +: 4], p[4*j +: 4], 1'b0);
            grp_g[j] = unit.gen;
            grp_p[j] = unit.prop;
        end
        // Each group carry is expanded from cin on its own, not chained off the previous one.
        for (int j = 0; j <= N_GRP; j++) begin
            grp_c[j] = cin;
            for (int k = 0; k < j; k++) begin
                grp_c[j] = grp_g[k] | (grp_p[k] & grp_c[j]);
            end
        end
        for (int j = 0; j < N_GRP; j++) begin
            unit         = cla4(g[4*j +: 4], p[4*j +: 4], grp_c[j]);
            c[4*j +: 4]  = unit.c;
        end
        c[SLICE_W] = grp_c[N_GRP];
    end

    assign sum      = p ^ c[SLICE_W-1:0];
    assign cout     = c[SLICE_W];
    assign c_msb_in = c[SLICE_W-1];

endmodule

// File: rtl/cla_multiword_add_seq.sv
// Wide add/subtract sequencer: one shared CLA slice, one slice per cycle LSB first,
// inter-slice carry held in a register; result and flags hold until the next operation.
module cla_multiword_add_seq
    import alu_pkg::*;
#(
    parameter int SLICE_W  = SLICE_W_DEF,
    parameter int N_SLICES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    cla_multiword_add_seq_if.slave bus
);

    localparam int                W        = SLICE_W * N_SLICES;
    localparam int                IDX_W    = idx_w(N_SLICES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               slice_c_msb;
    logic               accept;

    assign accept  = bus.start && (state_q != S_RUN);
    assign slice_a = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
    assign slice_b = b_q[int'(idx_q)*SLICE_W +: SLICE_W] ^ {SLICE_W{sub_q}};

    cla_slice_adder #(.SLICE_W(SLICE_W)) u_slice (
        .a        (slice_a),
        .b        (slice_b),
        .cin      (carry_q),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_c_msb)
    );

    // NOTE: every _d starts as its _q so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_d = S_RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    sub_d   = bus.op_sub;
                    carry_d = bus.op_sub ? 1'b1 : bus.c_in;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                sum_d[int'(idx_q)*SLICE_W +: SLICE_W] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    c_out_d = slice_cout;
                    ovf_d   = slice_c_msb ^ slice_cout;
                    zero_d  = (sum_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    assign bus.ready = (state_q != S_RUN);
    assign bus.busy  = (state_q == S_RUN);
    assign bus.done  = (state_q == S_DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.ovf   = ovf_q;
    assign bus.zero  = zero_q;

endmodule
